// File: rtl/mmio_bridge.sv
// mmio_bridge: splits core byte accesses between RAM and the I/O page.
// The I/O page holds the UART TX/RX FIFOs, a 32-bit cycle counter and the
// program-stop flag. Reads return data one cycle after the address.
module mmio_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [TXW:0] TX_THR  = (TXW+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  // Only address bits [17:0] are decoded.
  logic w_unused_addr;
  assign w_unused_addr = ^cpu_a[31:18];

  logic        w_is_io, w_rd, w_wr, w_io_rd, w_io_wr, w_off_data, w_off_cnt, w_off_stop;
  assign w_is_io    = (cpu_a[17:16] == 2'b11);
  assign w_rd       = rdy_in & ~cpu_wr;
  assign w_wr       = rdy_in & cpu_wr;
  assign w_io_rd    = w_rd & w_is_io;
  assign w_io_wr    = w_wr & w_is_io;
  assign w_off_data = (cpu_a[15:0] == 16'h0000);
  assign w_off_cnt  = (cpu_a[15:2] == 14'h0001);
  assign w_off_stop = (cpu_a[15:0] == 16'h0004);

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = w_wr & ~w_is_io;

  logic [31:0]  r_cnt, r_snap;
  logic         r_stop_pending;

  // ---------------- TX FIFO ----------------
  logic [7:0]   r_tx_mem [TX_DEPTH];
  logic [TXW-1:0] r_tx_wr, r_tx_rd;
  logic [TXW:0] r_tx_cnt, w_tx_cnt_nxt;
  logic         w_tx_req, w_tx_push, w_tx_pop;
  logic [7:0]   w_tx_wdata;

  // 0x00 to the data port is a no-op; the first stop write queues a 0x00 marker.
  assign w_tx_req   = w_io_wr & ((w_off_data & (cpu_dout != 8'h00)) |
                                 (w_off_stop & ~r_stop_pending));
  assign w_tx_wdata = w_off_data ? cpu_dout : 8'h00;
  assign w_tx_push  = w_tx_req & (r_tx_cnt != TX_FULL);
  assign w_tx_pop   = tx_valid & tx_ready;
  assign w_tx_cnt_nxt = r_tx_cnt + (TXW+1)'(w_tx_push) - (TXW+1)'(w_tx_pop);
  assign tx_valid   = (r_tx_cnt != '0);
  assign tx_data    = r_tx_mem[r_tx_rd];

  // TX storage; contents need no reset since the count gates them.
  always_ff @(posedge clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_tx_wdata;
  end

  // TX pointers, count, near-full flag and sticky overflow.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tx_wr        <= '0;
      r_tx_rd        <= '0;
      r_tx_cnt       <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + TXW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TXW'(1);
      r_tx_cnt       <= w_tx_cnt_nxt;
      io_buffer_full <= (w_tx_cnt_nxt >= TX_THR);
      if (w_tx_req && (r_tx_cnt == TX_FULL)) tx_overflow <= 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   r_rx_mem [RX_DEPTH];
  logic [RXW-1:0] r_rx_wr, r_rx_rd;
  logic [RXW:0] r_rx_cnt;
  logic         w_rx_push, w_rx_pop;

  assign w_rx_push = rx_valid & (r_rx_cnt != RX_FULL);
  assign w_rx_pop  = w_io_rd & w_off_data & (r_rx_cnt != '0);

  // RX storage.
  always_ff @(posedge clk_in) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  // RX pointers and count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RXW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RXW'(1);
      r_rx_cnt <= r_rx_cnt + (RXW+1)'(w_rx_push) - (RXW+1)'(w_rx_pop);
    end
  end

  // ---------------- counter, snapshot, stop ----------------
  // Free-running cycle counter; snapshot latched on a read of the low byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_io_rd && w_off_stop) r_snap <= r_cnt;
    end
  end

  // Stop request is remembered, then reported once the TX FIFO has drained.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_stop_pending <= 1'b0;
      prog_stop      <= 1'b0;
    end else begin
      if (w_io_wr && w_off_stop) r_stop_pending <= 1'b1;
      if (r_stop_pending && (r_tx_cnt == '0)) prog_stop <= 1'b1;
    end
  end

  // ---------------- read path ----------------
  logic [7:0] w_io_rdata, r_io_rdata, r_hold;
  logic       r_sel_io, r_prev_rd;

  // I/O read mux; byte 0 of the counter comes live so the snapshot stays coherent.
  always_comb begin
    w_io_rdata = 8'h00;
    if (w_off_data) begin
      if (r_rx_cnt != '0) w_io_rdata = r_rx_mem[r_rx_rd];
    end else if (w_off_cnt) begin
      case (cpu_a[1:0])
        2'd0:    w_io_rdata = r_cnt[7:0];
        2'd1:    w_io_rdata = r_snap[15:8];
        2'd2:    w_io_rdata = r_snap[23:16];
        default: w_io_rdata = r_snap[31:24];
      endcase
    end
  end

  // Capture read source and I/O data; remember last presented byte for freezes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel_io   <= 1'b0;
      r_prev_rd  <= 1'b0;
      r_io_rdata <= 8'h00;
      r_hold     <= 8'h00;
    end else begin
      r_prev_rd <= w_rd;
      r_hold    <= cpu_din;
      if (w_rd) begin
        r_sel_io   <= w_is_io;
        r_io_rdata <= w_io_rdata;
      end
    end
  end

  assign cpu_din = r_prev_rd ? (r_sel_io ? r_io_rdata : ram_din) : r_hold;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: reset, counter snapshot, TX/RX FIFOs,
// stop signalling, RAM path and mid-run reset.
module tb_mmio_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        prog_stop;
  logic        tx_overflow;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mem [256];

  mmio_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_we(ram_we), .ram_din(ram_din), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Small synchronous RAM with one-cycle read latency (low 8 address bits).
  always @(posedge clk_in) begin
    if (ram_we) mem[ram_a[7:0]] <= ram_dout;
    ram_din <= mem[ram_a[7:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_in = 1'b1; rdy_in = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) cyc();

    // Reset state
    check("rst_cpu_din", 32'(cpu_din), 32'h00);
    check("rst_full", 32'(io_buffer_full), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_prog_stop", 32'(prog_stop), 32'h0);
    check("rst_tx_overflow", 32'(tx_overflow), 32'h0);

    // Counter reaches 0x1FF after 511 clocks, then coherent 4-byte read
    rst_in = 1'b0;
    repeat (511) cyc();
    rdy_in = 1'b1; cpu_a = 32'h30004; cyc();
    check("cnt_b0", 32'(cpu_din), 32'hFF);
    cpu_a = 32'h30005; cyc();
    check("cnt_b1", 32'(cpu_din), 32'h01);
    rdy_in = 1'b0; cpu_a = 32'h0; cyc();
    check("cnt_hold_frozen", 32'(cpu_din), 32'h01);
    rdy_in = 1'b1; cpu_a = 32'h30006; cyc();
    check("cnt_b2", 32'(cpu_din), 32'h00);
    cpu_a = 32'h30007; cyc();
    check("cnt_b3", 32'(cpu_din), 32'h00);
    cpu_a = 32'h30005; cyc();
    check("cnt_b1_snap_held", 32'(cpu_din), 32'h01);
    cpu_a = 32'h30004; cyc();
    check("cnt2_b0", 32'(cpu_din), 32'h05);
    cpu_a = 32'h30005; cyc();
    check("cnt2_b1", 32'(cpu_din), 32'h02);
    cpu_a = 32'h30001; cyc();
    check("io_other_zero", 32'(cpu_din), 32'h00);

    // TX: 0x41, 0x00 (ignored), 0x42 with tx_ready high
    tx_ready = 1'b1; cpu_wr = 1'b1; cpu_a = 32'h30000; cpu_dout = 8'h41;
    #1 check("io_wr_no_ram_we", 32'(ram_we), 32'h0);
    cyc();
    check("tx1_valid", 32'(tx_valid), 32'h1);
    check("tx1_data", 32'(tx_data), 32'h41);
    cpu_dout = 8'h00; cyc();
    check("tx1_zero_ignored", 32'(tx_valid), 32'h0);
    cpu_dout = 8'h42; cyc();
    check("tx2_valid", 32'(tx_valid), 32'h1);
    check("tx2_data", 32'(tx_data), 32'h42);
    cpu_wr = 1'b0; cpu_a = 32'h0; cyc();
    check("tx_drained", 32'(tx_valid), 32'h0);

    // Near-full, fill, overflow
    tx_ready = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h30000; cpu_dout = 8'h55;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      if (i == 13) check("full_after_13", 32'(io_buffer_full), 32'h0);
    end
    check("full_after_14", 32'(io_buffer_full), 32'h1);
    cyc(); cyc();
    check("no_ovf_at_16", 32'(tx_overflow), 32'h0);
    cyc();
    check("ovf_at_17", 32'(tx_overflow), 32'h1);
    cpu_wr = 1'b0; cpu_a = 32'h0; tx_ready = 1'b1;
    repeat (16) cyc();
    check("fill_drained", 32'(tx_valid), 32'h0);
    check("full_cleared", 32'(io_buffer_full), 32'h0);
    check("ovf_sticky", 32'(tx_overflow), 32'h1);
    tx_ready = 1'b0;

    // RX FIFO
    rx_valid = 1'b1; rx_data = 8'h31; cyc();
    rx_data = 8'h32; cyc();
    rx_valid = 1'b0;
    cpu_a = 32'h30000; cyc();
    check("rx_0", 32'(cpu_din), 32'h31);
    cyc();
    check("rx_1", 32'(cpu_din), 32'h32);
    cyc();
    check("rx_empty", 32'(cpu_din), 32'h00);
    cpu_a = 32'h0;

    // Stop: three bytes queued, then stop marker, second stop ignored
    cpu_wr = 1'b1; cpu_a = 32'h30000;
    cpu_dout = 8'h11; cyc();
    cpu_dout = 8'h22; cyc();
    cpu_dout = 8'h33; cyc();
    cpu_a = 32'h30004; cpu_dout = 8'hAA; cyc();
    cyc();
    cpu_wr = 1'b0; cpu_a = 32'h0;
    check("stop_not_yet", 32'(prog_stop), 32'h0);
    tx_ready = 1'b1;
    #1 check("stop_seq0", 32'(tx_data), 32'h11);
    cyc();
    check("stop_seq1", 32'(tx_data), 32'h22);
    cyc();
    check("stop_seq2", 32'(tx_data), 32'h33);
    cyc();
    check("stop_seq3", 32'(tx_data), 32'h00);
    check("stop_seq3_valid", 32'(tx_valid), 32'h1);
    cyc();
    check("stop_only_one_marker", 32'(tx_valid), 32'h0);
    check("stop_pending_edge", 32'(prog_stop), 32'h0);
    cyc();
    check("prog_stop_set", 32'(prog_stop), 32'h1);
    tx_ready = 1'b0;

    // RAM write, read, freeze
    cpu_wr = 1'b1; cpu_a = 32'h00010; cpu_dout = 8'h7E;
    #1 check("ram_we_on", 32'(ram_we), 32'h1);
    check("ram_a_pass", 32'(ram_a), 32'h00010);
    check("ram_dout_pass", 32'(ram_dout), 32'h7E);
    cyc();
    cpu_wr = 1'b0; cyc();
    check("ram_read", 32'(cpu_din), 32'h7E);
    rdy_in = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h00020; cpu_dout = 8'h99;
    #1 check("ram_we_frozen", 32'(ram_we), 32'h0);
    cyc();
    check("din_held_frozen", 32'(cpu_din), 32'h7E);
    rdy_in = 1'b1; cpu_wr = 1'b0; cyc();
    check("ram_unwritten", 32'(cpu_din), 32'h00);

    // Reset in the middle of activity
    cpu_wr = 1'b1; cpu_a = 32'h30000; cpu_dout = 8'h5A; cyc(); cyc();
    cpu_wr = 1'b0; cpu_a = 32'h0;
    check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_prog_stop", 32'(prog_stop), 32'h0);
    check("mid_rst_ovf", 32'(tx_overflow), 32'h0);
    check("mid_rst_cpu_din", 32'(cpu_din), 32'h00);
    cyc();
    rst_in = 1'b0; cpu_a = 32'h30004; cyc();
    check("post_rst_cnt0", 32'(cpu_din), 32'h00);
    cyc();
    check("post_rst_cnt1", 32'(cpu_din), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
